// File: rtl/background_pkg.sv
// ---------------------------------------------------------------------------
// background_pkg
// Shared definitions for the background palette encoder (and its decoder
// counterpart background_CP). Both sides take the palette from this one
// table, so decode(encode(p)) == p holds for every palette colour.
//
// Contents:
//   color_idx_t  : 3-bit palette index
//   dist_t       : 6-bit Manhattan distance (max 3*15 = 45)
//   pixel_t      : RGB444 pixel, r in the MSBs
//   PALETTE      : 8 x RGB444 palette constants, PALETTE[i] is entry i
//   abs_diff4    : |a - b| for two 4-bit channel values
// ---------------------------------------------------------------------------
package background_pkg;

    localparam int NUM_COLORS = 8;

    typedef logic [2:0] color_idx_t;
    typedef logic [5:0] dist_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    // Entry 0 sits in the least significant slot of the packed array.
    localparam pixel_t [NUM_COLORS-1:0] PALETTE = {
        12'h6AF,  // 7
        12'h050,  // 6
        12'h8D0,  // 5
        12'h660,  // 4
        12'h520,  // 3
        12'h00F,  // 2
        12'h000,  // 1
        12'hF00   // 0
    };

    function automatic logic [3:0] abs_diff4(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/background_idx_encoder_if.sv
// ---------------------------------------------------------------------------
// background_idx_encoder_if
// Pixel-in / index-out stream bundle for background_idx_encoder.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// The producer holds valid and its data stable until that edge; ready may
// depend combinationally on the consumer's downstream ready but never on
// the producer's valid.
//
// Signals:
//   in_valid/in_ready/in_sof/in_r/in_g/in_b : RGB444 input stream, in_sof
//                                             marks the first pixel of a frame
//   out_valid/out_ready                     : encoded output stream
//   out_idx/out_addr/out_exact/frame_done   : nearest palette index, linear
//                                             address, zero-distance flag,
//                                             last-pixel-of-frame flag
// Modports:
//   master : environment side (drives pixels, accepts results)
//   slave  : encoder side
// ---------------------------------------------------------------------------
interface background_idx_encoder_if #(
    parameter int ADDR_W = 19
);
    import background_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [3:0]        in_r;
    logic [3:0]        in_g;
    logic [3:0]        in_b;

    logic              out_valid;
    logic              out_ready;
    color_idx_t        out_idx;
    logic [ADDR_W-1:0] out_addr;
    logic              out_exact;
    logic              frame_done;

    modport master (
        output in_valid, in_sof, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, out_idx, out_addr, out_exact, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, out_idx, out_addr, out_exact, frame_done
    );

endinterface

// File: rtl/background_idx_encoder_color_distance.sv
// ---------------------------------------------------------------------------
// color_distance
// Purely combinational |dR|+|dG|+|dB| between a pixel and one palette entry.
//
// Ports:
//   i_pix  : pixel under test (RGB444)
//   i_ref  : palette entry (RGB444)
//   o_dist : 6-bit unsigned distance, 0..45, never truncated
// ---------------------------------------------------------------------------
module color_distance
    import background_pkg::*;
(
    input  pixel_t i_pix,
    input  pixel_t i_ref,
    output dist_t  o_dist
);

    logic [3:0] w_dr;
    logic [3:0] w_dg;
    logic [3:0] w_db;

    assign w_dr = abs_diff4(i_pix.r, i_ref.r);
    assign w_dg = abs_diff4(i_pix.g, i_ref.g);
    assign w_db = abs_diff4(i_pix.b, i_ref.b);

    // Widen before adding so the 45-max sum cannot wrap.
    assign o_dist = {2'b00, w_dr} + {2'b00, w_dg} + {2'b00, w_db};

endmodule

// File: rtl/background_idx_encoder.sv
// ---------------------------------------------------------------------------
// background_idx_encoder
// Maps an RGB444 pixel stream onto the nearest of 8 palette colours and tags
// each result with its linear frame address y*WIDTH+x.
//
// Pipeline:
//   S1 : pixel, address, last-pixel flag and all 8 distances
//   S2 : min-select result (index, exact flag) with address and last flag
// Two cycles from input handshake to out_valid without backpressure; holds
// up to two pixels when out_ready is low.
//
// Parameters:
//   WIDTH, HEIGHT : frame geometry
//   ADDR_W        : address width, must satisfy 2**ADDR_W >= WIDTH*HEIGHT
// Ports:
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset, flushes the pipeline
//   bus   : stream interface (slave side)
// ---------------------------------------------------------------------------
module background_idx_encoder
    import background_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    background_idx_encoder_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    // ---------------- handshake / advance conditions ----------------
    logic w_s1_adv;
    logic w_s2_adv;
    logic w_in_fire;

    logic r_s1_valid;
    logic r_s2_valid;

    assign w_s2_adv  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_in_fire = bus.in_valid && w_s1_adv;
    assign bus.in_ready = w_s1_adv;

    // ---------------- address counter ----------------
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_pix_addr;
    logic              w_pix_last;

    // A start-of-frame pixel always takes address 0, wherever the count was.
    assign w_pix_addr = bus.in_sof ? '0 : r_addr;
    assign w_pix_last = (w_pix_addr == LAST_ADDR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= '0;
        end else if (w_in_fire) begin
            r_addr <= w_pix_last ? '0 : (w_pix_addr + ADDR_W'(1));
        end
    end

    // ---------------- distance computation ----------------
    pixel_t                      w_in_pix;
    dist_t [NUM_COLORS-1:0]      w_dist;

    assign w_in_pix = {bus.in_r, bus.in_g, bus.in_b};

    for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_dist
        color_distance u_dist (
            .i_pix  (w_in_pix),
            .i_ref  (PALETTE[gi]),
            .o_dist (w_dist[gi])
        );
    end

    // ---------------- stage 1 ----------------
    pixel_t                 r_s1_pix;
    logic [ADDR_W-1:0]      r_s1_addr;
    logic                   r_s1_last;
    dist_t [NUM_COLORS-1:0] r_s1_dist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_addr  <= '0;
            r_s1_last  <= 1'b0;
            r_s1_dist  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_pix  <= w_in_pix;
                r_s1_addr <= w_pix_addr;
                r_s1_last <= w_pix_last;
                r_s1_dist <= w_dist;
            end
        end
    end

    // ---------------- min select ----------------
    color_idx_t w_best_idx;
    dist_t      w_best_dist;
    logic       w_best_exact;

    // Strict less-than keeps the earlier index on equal distances.
    always_comb begin
        w_best_idx  = '0;
        w_best_dist = r_s1_dist[0];
        for (int i = 1; i < NUM_COLORS; i++) begin
            if (r_s1_dist[i] < w_best_dist) begin
                w_best_dist = r_s1_dist[i];
                w_best_idx  = color_idx_t'(i);
            end
        end
    end

    // Zero distance is the same as the pixel being the chosen palette colour.
    assign w_best_exact = (r_s1_pix == PALETTE[w_best_idx]);

    // ---------------- stage 2 ----------------
    color_idx_t        r_s2_idx;
    logic              r_s2_exact;
    logic [ADDR_W-1:0] r_s2_addr;
    logic              r_s2_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_exact <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_last  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_idx   <= w_best_idx;
                r_s2_exact <= w_best_exact;
                r_s2_addr  <= r_s1_addr;
                r_s2_last  <= r_s1_last;
            end
        end
    end

    assign bus.out_valid  = r_s2_valid;
    assign bus.out_idx    = r_s2_idx;
    assign bus.out_exact  = r_s2_exact;
    assign bus.out_addr   = r_s2_addr;
    // Stale S2 contents must not show a frame end once the pixel has left.
    assign bus.frame_done = r_s2_valid && r_s2_last;

endmodule

// File: tb/tb_background_idx_encoder.sv
// ---------------------------------------------------------------------------
// tb_background_idx_encoder
// Directed and randomized stimulus for background_idx_encoder on a 4x2
// frame, checked against a palette nearest-match model and an address model.
// ---------------------------------------------------------------------------
module tb_background_idx_encoder;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int ADDR_W = 3;
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int EW     = 1 + 1 + 3 + ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    background_idx_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    background_idx_encoder #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];   // {last, exact, idx[2:0], addr}
    int exp_addr = 0;
    int addr_log[$];
    int idx_log[$];
    int exact_log[$];
    int fd_count = 0;
    bit saw_stall = 0;
    bit done = 0;

    int pal_r[8] = '{15, 0,  0, 5, 6,  8, 0,  6};
    int pal_g[8] = '{ 0, 0,  0, 2, 6, 13, 5, 10};
    int pal_b[8] = '{ 0, 0, 15, 0, 0,  0, 0, 15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Nearest palette colour: find the smallest distance, then the first
    // entry that reaches it.
    function automatic void ref_encode(input int r, input int g, input int b,
                                       output int idx, output int exact);
        int d[8];
        int best;
        for (int i = 0; i < 8; i++) begin
            d[i] = ((r > pal_r[i]) ? r - pal_r[i] : pal_r[i] - r)
                 + ((g > pal_g[i]) ? g - pal_g[i] : pal_g[i] - g)
                 + ((b > pal_b[i]) ? b - pal_b[i] : pal_b[i] - b);
        end
        best = 1000;
        for (int i = 0; i < 8; i++) if (d[i] < best) best = d[i];
        idx = 0;
        for (int i = 7; i >= 0; i--) if (d[i] == best) idx = i;
        exact = (best == 0) ? 1 : 0;
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_pixel(input logic [3:0] r, input logic [3:0] g,
                              input logic [3:0] b, input logic sof);
        bit acc;
        int a;
        int idx;
        int ex;
        logic last;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_r = r;
        bus.in_g = g;
        bus.in_b = b;
        bus.in_sof = sof;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        if (!acc) begin
            check("accept_timeout", 0, 1);
        end else begin
            a = sof ? 0 : exp_addr;
            exp_addr = (a == NPIX - 1) ? 0 : a + 1;
            last = (a == NPIX - 1);
            ref_encode(int'(r), int'(g), int'(b), idx, ex);
            exp_q.push_back({last, ex[0], idx[2:0], a[ADDR_W-1:0]});
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 64 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_addr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        idx_log.delete();
        exact_log.delete();
        fd_count = 0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && bus.in_valid && !bus.in_ready) begin
            saw_stall = 1;
            check("stall_depth", exp_q.size(), 2);
        end
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_idx",    bus.out_idx,    e[EW-3 -: 3]);
                check("out_exact",  bus.out_exact,  e[EW-2]);
                check("out_addr",   bus.out_addr,   e[ADDR_W-1:0]);
                check("frame_done", bus.frame_done, e[EW-1]);
            end
            addr_log.push_back(int'(bus.out_addr));
            idx_log.push_back(int'(bus.out_idx));
            exact_log.push_back(int'(bus.out_exact));
            if (bus.frame_done) fd_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [3:0] rr;
        logic [3:0] gg;
        logic [3:0] bb;
        int k;

        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_r = '0;
        bus.in_g = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_out_idx",    bus.out_idx,    0);
        check("rst_out_addr",   bus.out_addr,   0);
        check("rst_out_exact",  bus.out_exact,  0);
        check("rst_frame_done", bus.frame_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", bus.in_ready, 1);

        // Exact match with two-cycle latency
        clear_logs();
        send_pixel(4'hF, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("lat_cycle1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", bus.out_valid, 1);
        check("exact_idx",   bus.out_idx,   0);
        check("exact_flag",  bus.out_exact, 1);
        check("exact_addr",  bus.out_addr,  0);
        @(posedge clk);
        #1;

        // Nearest match
        clear_logs();
        send_pixel(4'h7, 4'h7, 4'h1, 1'b0);
        drain();
        check("near_count", idx_log.size(), 1);
        if (idx_log.size() > 0) begin
            check("near_idx",   idx_log[0],   4);
            check("near_exact", exact_log[0], 0);
            check("near_addr",  addr_log[0],  1);
        end

        // Tie between entries 3 and 6
        clear_logs();
        send_pixel(4'h3, 4'h4, 4'h0, 1'b0);
        drain();
        check("tie_count", idx_log.size(), 1);
        if (idx_log.size() > 0) begin
            check("tie_idx",  idx_log[0],  3);
            check("tie_addr", addr_log[0], 2);
        end

        // Every palette colour maps to itself exactly
        clear_logs();
        for (int i = 0; i < 8; i++) send_pixel(4'(pal_r[i]), 4'(pal_g[i]), 4'(pal_b[i]), 1'b0);
        drain();
        check("pal_count", idx_log.size(), 8);
        for (int i = 0; i < idx_log.size(); i++) begin
            check("pal_idx",   idx_log[i],   i);
            check("pal_exact", exact_log[i], 1);
        end

        // Backpressure: out_ready low for four cycles mid-stream
        apply_reset();
        clear_logs();
        saw_stall = 0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_pixel(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                               4'($urandom_range(0, 15)), 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_stall_seen", saw_stall, 1);
        check("bp_count", addr_log.size(), 5);
        for (int i = 0; i < addr_log.size(); i++) check("bp_addr_order", addr_log[i], i);

        // Address wrap on a 4x2 frame
        apply_reset();
        clear_logs();
        for (int i = 0; i < 9; i++)
            send_pixel(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 1'b0);
        drain();
        check("wrap_count", addr_log.size(), 9);
        if (addr_log.size() == 9) begin
            check("wrap_addr7", addr_log[7], 7);
            check("wrap_addr8", addr_log[8], 0);
        end
        check("wrap_frame_done_count", fd_count, 1);

        // Asynchronous reset with a pixel on the output
        send_pixel(4'h1, 4'h2, 4'h3, 1'b0);
        send_pixel(4'h4, 4'h5, 4'h6, 1'b0);
        check("pre_reset_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_addr",  bus.out_addr,  0);
        exp_q.delete();
        exp_addr = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        clear_logs();
        send_pixel(4'h9, 4'h9, 4'h9, 1'b0);
        drain();
        check("post_rst_count", addr_log.size(), 1);
        if (addr_log.size() > 0) check("post_rst_addr", addr_log[0], 0);

        // Start of frame on the third pixel
        apply_reset();
        clear_logs();
        send_pixel(4'h2, 4'h2, 4'h2, 1'b0);
        send_pixel(4'h3, 4'h3, 4'h3, 1'b0);
        send_pixel(4'h4, 4'h4, 4'h4, 1'b1);
        drain();
        check("sof_count", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check("sof_addr0", addr_log[0], 0);
            check("sof_addr1", addr_log[1], 1);
            check("sof_addr2", addr_log[2], 0);
        end

        // Randomized traffic with gaps, SOFs and random backpressure
        apply_reset();
        clear_logs();
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        k = $urandom_range(0, 7);
                        rr = 4'(pal_r[k]);
                        gg = 4'(pal_g[k]);
                        bb = 4'(pal_b[k]);
                    end else begin
                        rr = 4'($urandom_range(0, 15));
                        gg = 4'($urandom_range(0, 15));
                        bb = 4'($urandom_range(0, 15));
                    end
                    send_pixel(rr, gg, bb, ($urandom_range(0, 19) == 0));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain();
        check("rand_count", addr_log.size(), 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/background_idx_encoder.md
BACKGROUND_IDX_ENCODER -- requirements
Module: background_idx_encoder

Interface
REQ-001 The block SHALL have exactly one clock and exactly one reset; the reset SHALL be asynchronous and active-high.
REQ-002 Parameter WIDTH, default 640: pixels per line.
REQ-003 Parameter HEIGHT, default 480: lines per frame.
REQ-004 Parameter ADDR_W, default 19: address width; SHALL satisfy 2^ADDR_W >= WIDTH*HEIGHT.
REQ-005 Clk  input  1  rising-edge clock for all state.
REQ-006 Reset  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  input pixel present.
REQ-008 in_ready  output  1  block accepts the input pixel this cycle.
REQ-009 in_sof  input  1  start of frame; qualified by in_valid.
REQ-010 in_r, in_g, in_b  input  4 each  RGB444 pixel.
REQ-011 out_valid  output  1  encoded pixel present.
REQ-012 out_ready  input  1  downstream accepts the encoded pixel.
REQ-013 out_idx  output  3  palette index, nearest match.
REQ-014 out_addr  output  ADDR_W  linear pixel address, y*WIDTH+x.
REQ-015 out_exact  output  1  high when the match distance is 0.
REQ-016 frame_done  output  1  high with the pixel whose out_addr is WIDTH*HEIGHT-1.

Function
REQ-017 Palette entries (R,G,B) SHALL be: 0=(F,0,0), 1=(0,0,0), 2=(0,0,F), 3=(5,2,0), 4=(6,6,0), 5=(8,D,0), 6=(0,5,0), 7=(6,A,F).
REQ-018 Distance SHALL be |dR|+|dG|+|dB| as an unsigned 6-bit value (max 45), with no truncation.
REQ-019 out_idx SHALL be the index with minimum distance; on ties, the lowest index SHALL win.
REQ-020 The block SHALL have a 2-stage pipeline. S1 registers the pixel and address plus the 8 distances. S2 registers the min-select result.
REQ-021 Latency SHALL be 2 cycles from input handshake to out_valid when there is no backpressure.
REQ-022 Handshakes occur when valid&&ready; valid and data SHALL be held stable until accepted.
REQ-023 S2 advances when !s2_valid || out_ready.
REQ-024 S1 advances when !s1_valid || S2 advances.
REQ-025 in_ready SHALL equal the S1-advance condition. It is combinational from out_ready; no combinational path from in_valid.
REQ-026 Throughput SHALL be 1 pixel/cycle while out_ready=1. With out_ready=0, up to 2 pixels are held, with no loss or reorder.
REQ-027 The address counter SHALL increment on each input handshake and be captured into S1 with the pixel.
REQ-028 An accepted in_sof pixel SHALL get address 0; the counter then continues from 1.
REQ-029 After address WIDTH*HEIGHT-1 the counter SHALL wrap to 0.
REQ-030 frame_done SHALL travel with its pixel through the pipeline. It is valid only with out_valid.
REQ-031 When in_sof arrives mid-frame, the counter SHALL restart at 0 and no frame_done is produced for the truncated frame.

Reset
REQ-032 On Reset, out_valid=0, s1_valid=0, the address counter=0, and out_idx, out_addr, out_exact and frame_done=0. in_ready SHALL be 1 one cycle after Reset deasserts.
REQ-033 Reset asserted mid-stream SHALL discard in-flight pixels immediately (asynchronously). The next accepted pixel SHALL get address 0.

Structure
REQ-034 Package background_pkg SHALL hold: the palette table (8 x RGB444 constants), the color index type (3 bits), the distance type (6 bits), and the pixel type (RGB444 struct).
REQ-035 One sub-module, color_distance (purely combinational: pixel + palette entry -> distance), SHALL be instantiated 8 times.
REQ-036 background_CP and this block SHALL share background_pkg palette constants, so that decode(encode(p))==p for every palette color.

Verification
REQ-037 Exact match: reset; stream (F,0,0) with out_ready=1 -> 2 cycles later out_idx=0, out_exact=1, out_addr=0.
REQ-038 Nearest match: (7,7,1) -> out_idx=4, out_exact=0.
REQ-039 Tie: (3,4,0) gives distance 4 to entries 3 and 6 -> out_idx=3.
REQ-040 Backpressure: stream 5 pixels, out_ready=0 for cycles 2-5.
  - in_ready SHALL fall after 2 pixels are held.
  - All 5 pixels SHALL emerge in order with addresses 0-4.
REQ-041 Wrap: WIDTH=4, HEIGHT=2, 9 pixels -> addresses 0..7 then 0; frame_done only on address 7.
REQ-042 Reset/SOF:
  - Reset pulse with out_valid=1 -> out_valid=0 in the same cycle; the next pixel gets address 0.
  - in_sof on the 3rd pixel -> addresses 0,1,0.
